// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage buffer: state encoding
// and the EX/MEM data bundle layout.
package pipe_pkg;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int EXMEM_W          = 102;
  localparam int WRITE_REG_LSB    = 0;
  localparam int WRITE_REG_W      = 5;
  localparam int READ_DATA2_LSB   = 5;
  localparam int READ_DATA2_W     = 32;
  localparam int ALU_RESULT_LSB   = 37;
  localparam int ALU_RESULT_W     = 32;
  localparam int ZERO_LSB         = 69;
  localparam int BRANCH_ADDR_LSB  = 70;
  localparam int BRANCH_ADDR_W    = 32;

  function automatic logic [EXMEM_W-1:0] pack_ex_mem(
    input logic [BRANCH_ADDR_W-1:0] branch_addr,
    input logic                     zero,
    input logic [ALU_RESULT_W-1:0]  alu_result,
    input logic [READ_DATA2_W-1:0]  read_data2,
    input logic [WRITE_REG_W-1:0]   write_reg
  );
    logic [EXMEM_W-1:0] b;
    b = '0;
    b[BRANCH_ADDR_LSB +: BRANCH_ADDR_W] = branch_addr;
    b[ZERO_LSB]                         = zero;
    b[ALU_RESULT_LSB +: ALU_RESULT_W]   = alu_result;
    b[READ_DATA2_LSB +: READ_DATA2_W]   = read_data2;
    b[WRITE_REG_LSB +: WRITE_REG_W]     = write_reg;
    return b;
  endfunction

  function automatic logic [ALU_RESULT_W-1:0] ex_mem_alu_result(input logic [EXMEM_W-1:0] b);
    return b[ALU_RESULT_LSB +: ALU_RESULT_W];
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One ctrl+data holding register. Reset clears everything; clear always
// drops ctrl and drops data only when CLEAR_DATA is set.
module pipe_slot #(
  parameter int CTRL_W     = 5,
  parameter int DATA_W     = 102,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (clear) begin
      q_ctrl <= '0;
      if (CLEAR_DATA != 0) q_data <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Generic pipeline-stage register with valid/ready handshake, a two-entry
// skid so in_ready is registered, flush-to-bubble and an occupancy count.
module pipe_skid_buffer #(
  parameter int CTRL_W     = 5,
  parameter int DATA_W     = 102,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);
  import pipe_pkg::*;

  // Handshake: a transfer happens on a rising clk where valid && ready;
  // upstream holds in_* stable while in_valid && !in_ready.
  state_t state, next_state;
  logic in_xfer, out_xfer;
  logic main_load, skid_load;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;

  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign count     = state;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (in_xfer) next_state = ONE;
      ONE: begin
        if (in_xfer && !out_xfer)      next_state = FULL;
        else if (!in_xfer && out_xfer) next_state = EMPTY;
      end
      FULL:    if (out_xfer) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
    end
  end

  // Main refills from the skid when draining FULL, otherwise from upstream.
  assign main_load   = (state == EMPTY && in_xfer) ||
                       (state == ONE && in_xfer && out_xfer) ||
                       (state == FULL && out_xfer);
  assign skid_load   = (state == ONE) && in_xfer && !out_xfer;
  assign main_d_ctrl = (state == FULL) ? skid_ctrl : in_ctrl;
  assign main_d_data = (state == FULL) ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (main_load),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .q_ctrl (main_ctrl),
    .q_data (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (skid_load),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data)
  );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed bench for pipe_skid_buffer: scoreboard on the main instance,
// plus a CLEAR_DATA=0 instance for the data-hold flush behaviour.
module tb_pipe_skid_buffer;
  import pipe_pkg::*;

  localparam int CTRL_W = 5;
  localparam int DATA_W = 102;
  localparam int PW     = CTRL_W + DATA_W;

  logic              clk;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        count;

  logic              h_reset, h_flush, h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [CTRL_W-1:0] h_in_ctrl, h_out_ctrl;
  logic [DATA_W-1:0] h_in_data, h_out_data;
  logic [1:0]        h_count;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  pipe_skid_buffer #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .count(count)
  );

  pipe_skid_buffer #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(0)) dut_hold (
    .clk(clk), .reset(h_reset), .flush(h_flush),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_ctrl(h_in_ctrl), .in_data(h_in_data),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_ctrl(h_out_ctrl), .out_data(h_out_data),
    .count(h_count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] pl(input logic [31:0] alu);
    return pack_ex_mem(32'h0040_0000 + alu, alu[0], alu, ~alu, alu[4:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] alu);
    in_valid = 1'b1;
    in_ctrl  = 5'b10001;
    in_data  = pl(alu);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (count != 2'd0 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_count"}, 128'(count), 128'd0);
    check({tag, "_q_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  // Scoreboard: entries accepted upstream are expected downstream in order;
  // reset or flush discards everything held.
  always @(negedge clk) begin
    logic [PW-1:0] exp;
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out: observed %0h expected no output", {out_ctrl, out_data});
        end
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          checks++;
          assert ({out_ctrl, out_data} === exp) else begin
            errors++;
            $error("FAIL sb_out: observed %0h expected %0h", {out_ctrl, out_data}, exp);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    h_reset = 1'b0; h_flush = 1'b0; h_in_valid = 1'b0; h_in_ctrl = '0; h_in_data = '0;
    h_out_ready = 1'b0;

    // Reset
    repeat (2) tick();
    reset = 1'b1;
    h_reset = 1'b1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_ctrl", 128'(out_ctrl), 128'd0);
    check("rst_out_data", 128'(out_data), 128'd0);
    check("rst_count", 128'(count), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(32'h10 + 32'(i));
      tick();
      check("stream_count", 128'(count), 128'd1);
      check("stream_in_ready", 128'(in_ready), 128'd1);
      check("stream_ctrl", 128'(out_ctrl), 128'b10001);
    end
    drain("stream");

    // Stall into FULL, then release
    out_ready = 1'b0;
    push(32'hA1); tick();
    push(32'hA2); tick();
    check("stall_count", 128'(count), 128'd2);
    check("stall_in_ready", 128'(in_ready), 128'd0);
    push(32'hA3); tick();
    check("stall_hold_count", 128'(count), 128'd2);
    check("stall_head", 128'(out_data), 128'(pl(32'hA1)));
    out_ready = 1'b1;
    tick();
    check("stall_second", 128'(out_data), 128'(pl(32'hA2)));
    check("stall_ready_back", 128'(in_ready), 128'd1);
    tick();
    check("stall_third", 128'(out_data), 128'(pl(32'hA3)));
    drain("stall");

    // Flush in FULL with a simultaneous input
    out_ready = 1'b0;
    push(32'hB1); tick();
    push(32'hB2); tick();
    check("pre_flush_count", 128'(count), 128'd2);
    flush = 1'b1;
    push(32'hB3);
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 128'(out_valid), 128'd0);
    check("flush_out_ctrl", 128'(out_ctrl), 128'd0);
    check("flush_count", 128'(count), 128'd0);
    check("flush_out_data", 128'(out_data), 128'd0);
    check("flush_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("flush_no_b3", 128'(out_valid), 128'd0);

    // Simultaneous in/out in ONE
    out_ready = 1'b0;
    push(32'hC1); tick();
    check("sim_pre", 128'(out_data), 128'(pl(32'hC1)));
    out_ready = 1'b1;
    push(32'hC2); tick();
    check("sim_data", 128'(out_data), 128'(pl(32'hC2)));
    check("sim_alu", 128'(ex_mem_alu_result(out_data)), 128'h000000C2);
    check("sim_count", 128'(count), 128'd1);
    drain("sim");

    // Reset while FULL with a pending output transfer
    out_ready = 1'b0;
    push(32'hE1); tick();
    push(32'hE2); tick();
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_count", 128'(count), 128'd0);
    check("mid_rst_valid", 128'(out_valid), 128'd0);
    check("mid_rst_data", 128'(out_data), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    repeat (2) tick();
    check("mid_rst_quiet", 128'(out_valid), 128'd0);

    // CLEAR_DATA=0: flush keeps data, reset still clears it
    h_in_valid = 1'b1; h_in_ctrl = 5'b10001; h_in_data = pl(32'hD1);
    tick();
    h_in_valid = 1'b0;
    check("hold_loaded", 128'(h_out_data), 128'(pl(32'hD1)));
    h_flush = 1'b1;
    tick();
    h_flush = 1'b0;
    check("hold_flush_data", 128'(h_out_data), 128'(pl(32'hD1)));
    check("hold_flush_ctrl", 128'(h_out_ctrl), 128'd0);
    check("hold_flush_count", 128'(h_count), 128'd0);
    check("hold_flush_valid", 128'(h_out_valid), 128'd0);
    h_in_valid = 1'b1; h_in_data = pl(32'hD2);
    tick();
    h_in_valid = 1'b0;
    check("hold_d2", 128'(h_out_data), 128'(pl(32'hD2)));
    h_flush = 1'b1;
    h_reset = 1'b0;
    tick();
    h_flush = 1'b0;
    h_reset = 1'b1;
    check("hold_rst_data", 128'(h_out_data), 128'd0);
    check("hold_rst_count", 128'(h_count), 128'd0);
    check("hold_rst_in_ready", 128'(h_in_ready), 128'd1);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
